// File: rtl/r200_fetchq.sv
// ---------------------------------------------------------------------------
// r200_fetchq -- instruction prefetch queue for the r200 pipeline.
//
// Sits between the instruction memory and the IF/ID register. Issues
// sequential word fetches, buffers returned instructions together with their
// PC in a DEPTH-entry FIFO and hands one instruction per cycle to IF/ID under
// a valid/ready handshake. A redirect (taken branch/jump) flushes the FIFO,
// marks every in-flight request as stale and restarts fetching at the target.
//
// Parameters:
//   DEPTH     FIFO entries and maximum outstanding requests (power of 2, 2..16)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        synchronous active-low reset
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch address, bits [1:0] ignored
//   imem_req     fetch request valid
//   imem_addr    fetch word address (bits [1:0] always 0)
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  response valid (in request order, latency >= 1)
//   imem_rdata   instruction word of the response
//   out_valid    out_instrn/out_pc/out_pcp4 hold a valid instruction
//   out_ready    IF/ID consumes the head entry (low = stall)
//   out_instrn   instruction
//   out_pc       address of out_instrn
//   out_pcp4     out_pc + 4 (wrapping)
//
// Build option:
//   R200_FETCHQ_BYPASS_EN  when defined, a response arriving while the queue
//   is empty (and nothing is being discarded) drives out_* in the same cycle
//   and is consumed directly if out_ready is high. When undefined, out_* come
//   only from registered FIFO state.
// ---------------------------------------------------------------------------
module r200_fetchq #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instrn,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcp4
);

  localparam int          AW         = $clog2(DEPTH);
  localparam int          CW         = AW + 1;
  localparam logic [CW:0] DEPTH_C    = (CW + 1)'(DEPTH);
  localparam logic [31:0] RESET_WORD = {RESET_PC[31:2], 2'b00};

  // Control state
  logic [31:0]   fetch_pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] pq_wr;
  logic [AW-1:0] pq_rd;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  // Data storage (never reset; validity is tracked by the counters)
  logic [31:0] fifo_instrn [DEPTH];
  logic [31:0] fifo_pc     [DEPTH];
  logic [31:0] pcq         [DEPTH];

  logic [CW:0]   in_use;
  logic          accept;
  logic          resp_ok;
  logic          resp_live;
  logic          head_valid;
  logic          pop;
  logic          fifo_pop;
  logic          push;
  logic [31:0]   head_instrn;
  logic [31:0]   head_pc;
  logic [CW-1:0] outstanding_nx;
  logic [CW-1:0] discard_nx;
  logic [CW-1:0] count_nx;

  logic unused_redir_lsb;
  assign unused_redir_lsb = ^redirect_pc[1:0];

  // Request issue: credits cover both buffered entries and in-flight
  // requests, so every response is guaranteed a free FIFO slot.
  always_comb begin
    in_use    = {1'b0, count} + {1'b0, outstanding};
    imem_req  = rst_n && !redirect && (in_use < DEPTH_C);
    imem_addr = fetch_pc;
    accept    = imem_req && imem_gnt;
  end

  // A response with nothing outstanding is a protocol error and is ignored.
  // Responses that arrive while discard is non-zero belong to a fetch stream
  // that a redirect has already abandoned.
  always_comb begin
    resp_ok     = imem_rvalid && (outstanding != '0);
    resp_live   = resp_ok && (discard == '0);
    head_valid  = (count != '0);
    head_instrn = head_valid ? fifo_instrn[rd_ptr] : 32'h0;
    head_pc     = head_valid ? fifo_pc[rd_ptr]     : 32'h0;
  end

`ifdef R200_FETCHQ_BYPASS_EN
  logic byp;

  always_comb begin
    byp       = !head_valid && resp_live && !redirect;
    out_valid = head_valid || byp;
    if (byp) begin
      out_instrn = imem_rdata;
      out_pc     = pcq[pq_rd];
    end else begin
      out_instrn = head_instrn;
      out_pc     = head_pc;
    end
    // A bypassed response taken by IF/ID this cycle never enters the FIFO.
    push = resp_live && !redirect && !(byp && out_ready);
  end
`else
  always_comb begin
    out_valid  = head_valid;
    out_instrn = head_instrn;
    out_pc     = head_pc;
    push       = resp_live && !redirect;
  end
`endif

  assign out_pcp4 = out_pc + 32'd4;

  // Pops in a redirect cycle are ignored: the whole queue is being flushed.
  always_comb begin
    pop      = out_valid && out_ready && !redirect;
    fifo_pop = pop && head_valid;
  end

  // Counter updates. In a redirect cycle no request is issued, so the
  // post-cycle outstanding count equals the number of responses still due,
  // and all of those are stale.
  always_comb begin
    outstanding_nx = outstanding + CW'(accept) - CW'(resp_ok);
    if (redirect) begin
      discard_nx = outstanding_nx;
      count_nx   = '0;
    end else begin
      discard_nx = discard - CW'(resp_ok && (discard != '0));
      count_nx   = count + CW'(push) - CW'(fifo_pop);
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_WORD;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pq_wr       <= '0;
      pq_rd       <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (redirect) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(push);
        rd_ptr <= rd_ptr + AW'(fifo_pop);
      end

      // The request-PC queue keeps running across redirects so that stale
      // responses still retire their own PC slots in order.
      pq_wr       <= pq_wr + AW'(accept);
      pq_rd       <= pq_rd + AW'(resp_ok);
      count       <= count_nx;
      outstanding <= outstanding_nx;
      discard     <= discard_nx;
    end
  end

  // Data registers
  always_ff @(posedge clk) begin
    if (accept) begin
      pcq[pq_wr] <= fetch_pc;
    end
    if (push) begin
      fifo_instrn[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]     <= pcq[pq_rd];
    end
  end

endmodule

// File: tb/tb_r200_fetchq.sv
// ---------------------------------------------------------------------------
// Testbench for r200_fetchq (DEPTH=4, RESET_PC=0).
// A memory model with programmable latency and a grant budget serves fetches;
// a monitor checks every accepted imem_addr and every popped instruction
// against queues of expected values filled by the directed test sequence.
// ---------------------------------------------------------------------------
module tb_r200_fetchq;

  localparam int DEPTH = 4;
`ifdef R200_FETCHQ_BYPASS_EN
  localparam int BYP_LAT = 0;
`else
  localparam int BYP_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instrn;
  logic [31:0] out_pc;
  logic [31:0] out_pcp4;

  r200_fetchq #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instrn(out_instrn),
    .out_pc(out_pc), .out_pcp4(out_pcp4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          gnt_limit = 0;
  int          acc_cnt = 0;
  logic        mem_flush = 1'b1;
  req_t        pend[$];
  logic        nxt_rvalid = 1'b0;
  logic [31:0] nxt_rdata = 32'h0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_addr_q[$];
  int          pops[$];
  int          rv_cyc[$];
  logic [31:0] mon_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(base + 32'(4 * i));
      exp_pc_q.push_back(base + 32'(4 * i));
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_pc_q.size() != 0 || exp_addr_q.size() != 0) && n < budget) begin
      next();
      n++;
    end
    total++;
    if (exp_pc_q.size() != 0 || exp_addr_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d pcs and %0d addrs left, want 0", exp_pc_q.size(), exp_addr_q.size());
      exp_pc_q.delete();
      exp_addr_q.delete();
    end
    next();
    next();
  endtask

  // Leaves the bench at the start of the first cycle with rst_n high.
  task automatic reset_dut();
    next();
    rst_n = 1'b0;
    mem_flush = 1'b1;
    redirect = 1'b0;
    gnt_limit = 0;
    next();
    next();
    rst_n = 1'b1;
    mem_flush = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: accepts on req&&gnt, answers in order after lat cycles.
  initial forever begin
    @(negedge clk);
    if (mem_flush) begin
      pend.delete();
      nxt_rvalid = 1'b0;
      acc_cnt = 0;
    end else begin
      if (imem_req && imem_gnt) begin
        pend.push_back('{addr: imem_addr, due: cyc + lat});
        acc_cnt++;
      end
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        nxt_rvalid = 1'b1;
        nxt_rdata = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        nxt_rvalid = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    imem_rvalid = nxt_rvalid;
    imem_rdata = nxt_rdata;
    imem_gnt = (acc_cnt < gnt_limit);
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (imem_rvalid) rv_cyc.push_back(cyc);
    if (rst_n && imem_req && imem_gnt) begin
      if (exp_addr_q.size() > 0) begin
        check("imem_addr", imem_addr, exp_addr_q.pop_front());
      end else begin
        total++;
        bad++;
        $display("FAIL imem_addr: unexpected accept of %h", imem_addr);
      end
    end
    if (rst_n && out_valid && out_ready && !redirect) begin
      pops.push_back(cyc);
      if (exp_pc_q.size() > 0) begin
        mon_e = exp_pc_q.pop_front();
        check("out_pc", out_pc, mon_e);
        check("out_instrn", out_instrn, mem_word(mon_e));
        check("out_pcp4", out_pcp4, mon_e + 32'd4);
      end else begin
        total++;
        bad++;
        $display("FAIL out_pc: unexpected pop of %h", out_pc);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    next();
    next();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instrn", out_instrn, 32'h0);

    // Reset then run: 1-cycle memory, one instruction per cycle
    next();
    rst_n = 1'b1;
    mem_flush = 1'b0;
    out_ready = 1'b1;
    lat = 1;
    gnt_limit = 6;
    pops.delete();
    expect_seq(32'h0, 6);
    @(negedge clk);
    check("first_cycle_req", 32'(imem_req), 32'd1);
    check("first_cycle_valid", 32'(out_valid), 32'd0);
    wait_drain(40);
    check("run_npops", 32'(pops.size()), 32'd6);
    if (pops.size() == 6) check("run_span", 32'(pops[5] - pops[0]), 32'd5);

    // Grant withheld: request address must hold
    for (int i = 0; i < 5; i++) begin
      next();
      @(negedge clk);
      check("addr_held", imem_addr, 32'h18);
      check("req_held", 32'(imem_req), 32'd1);
    end
    next();
    gnt_limit = 8;
    expect_seq(32'h18, 2);
    wait_drain(40);

    // Stall to full
    reset_dut();
    out_ready = 1'b0;
    lat = 1;
    gnt_limit = 8;
    pops.delete();
    expect_seq(32'h0, 8);
    repeat (8) next();
    @(negedge clk);
    check("full_accepts", 32'(acc_cnt), 32'd4);
    check("full_req", 32'(imem_req), 32'd0);
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_head_pc", out_pc, 32'h0);
    check("full_head_instrn", out_instrn, mem_word(32'h0));
    next();
    out_ready = 1'b1;
    wait_drain(40);
    check("drain_npops", 32'(pops.size()), 32'd8);
    if (pops.size() == 8) check("drain_span4", 32'(pops[3] - pops[0]), 32'd3);

    // Redirect with 3 requests in flight
    reset_dut();
    out_ready = 1'b1;
    lat = 4;
    gnt_limit = 3;
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    repeat (3) next();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    gnt_limit = 7;
    expect_seq(32'h100, 4);
    @(negedge clk);
    check("redir_req", 32'(imem_req), 32'd0);
    next();
    redirect = 1'b0;
    @(negedge clk);
    check("redir_next_valid", 32'(out_valid), 32'd0);
    check("redir_next_addr", imem_addr, 32'h100);
    check("redir_next_req", 32'(imem_req), 32'd1);
    wait_drain(80);

    // Address wrap at the top of the address space
    next();
    lat = 1;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    gnt_limit = gnt_limit + 3;
    expect_seq(32'hFFFF_FFF8, 3);
    next();
    redirect = 1'b0;
    wait_drain(40);

    // Back-to-back redirects with responses pending
    next();
    lat = 3;
    gnt_limit = gnt_limit + 6;
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    next();
    next();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(32'h300 + 32'(4 * i));
      exp_pc_q.push_back(32'h300 + 32'(4 * i));
    end
    @(negedge clk);
    check("b2b_req0", 32'(imem_req), 32'd0);
    next();
    redirect_pc = 32'h300;
    @(negedge clk);
    check("b2b_req1", 32'(imem_req), 32'd0);
    next();
    redirect = 1'b0;
    wait_drain(80);

    // Queue latency from an empty queue
    next();
    lat = 1;
    out_ready = 1'b1;
    rv_cyc.delete();
    pops.delete();
    gnt_limit = gnt_limit + 1;
    expect_seq(32'h310, 1);
    wait_drain(40);
    check("lat_nresp", 32'(rv_cyc.size()), 32'd1);
    if (rv_cyc.size() == 1 && pops.size() == 1)
      check("lat_cycles", 32'(pops[0] - rv_cyc[0]), 32'(BYP_LAT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
